// File: rtl/stream_dispatcher_pkg.sv
// Shared constants and state encoding for the stream dispatcher.
// Word width, destination count, select width and FSM states.
package stream_dispatcher_pkg;

   localparam int WORD_W   = 16;
   localparam int SD_NDEST = 4;
   localparam int SEL_W    = 2;
   localparam int CNT_W    = 16;

   typedef enum logic {
      EMPTY = 1'b0,
      HOLD  = 1'b1
   } sd_state_t;

endpackage

// File: rtl/stream_dispatcher_dmux4way.sv
// One-hot 1-to-4 demultiplexer used for the out_valid decode.
// Ports: in (bit to route), sel (2-bit index), a..d (outputs 0..3).
module dmux4way (
   input  logic       in,
   input  logic [1:0] sel,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       d
);

   always_comb begin
      a = 1'b0;
      b = 1'b0;
      c = 1'b0;
      d = 1'b0;
      unique case (sel)
         2'd0: a = in;
         2'd1: b = in;
         2'd2: c = in;
         2'd3: d = in;
         default: a = 1'b0;
      endcase
   end

endmodule

// File: rtl/stream_dispatcher.sv
// Single-word buffer routing a stream to one of four destinations.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_data,
//   in_dest_en/in_dest (directed vs round-robin); out_valid (one-hot),
//   out_ready, out_data (broadcast), sel, dispatch_count.
module stream_dispatcher
   import stream_dispatcher_pkg::*;
#(
   parameter int WIDTH = WORD_W,
   parameter int NDEST = SD_NDEST
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic               in_dest_en,
   input  logic [SEL_W-1:0]   in_dest,
   output logic [NDEST-1:0]   out_valid,
   input  logic [NDEST-1:0]   out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [SEL_W-1:0]   sel,
   output logic [CNT_W-1:0]   dispatch_count
);

   sd_state_t        state;
   sd_state_t        state_n;
   logic [SEL_W-1:0] rr_ptr;
   logic [SEL_W-1:0] rr_nxt;
   logic             rr_word;
   logic             hold;
   logic             dispatch;
   logic             accept;

   assign hold     = (state == HOLD);
   assign dispatch = hold & out_ready[sel];
   assign in_ready = rst_n & (~hold | dispatch);
   assign accept   = in_valid & in_ready;

   // A word accepted on the same edge that retires a round-robin
   // word must see the already-advanced pointer.
   assign rr_nxt = rr_ptr + SEL_W'(dispatch & rr_word);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         EMPTY:   if (accept) state_n = HOLD;
         HOLD:    if (dispatch && !accept) state_n = EMPTY;
         default: state_n = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr         <= '0;
         rr_word        <= 1'b0;
         sel            <= '0;
         out_data       <= '0;
         dispatch_count <= '0;
      end else begin
         rr_ptr <= rr_nxt;
         if (dispatch)
            dispatch_count <= dispatch_count + 1'b1;
         if (accept) begin
            out_data <= in_data;
            rr_word  <= ~in_dest_en;
            sel      <= in_dest_en ? in_dest : rr_nxt;
         end
      end
   end

   logic [3:0] ov;

   dmux4way u_dmux (
      .in  (hold),
      .sel (sel),
      .a   (ov[0]),
      .b   (ov[1]),
      .c   (ov[2]),
      .d   (ov[3])
   );

   assign out_valid = NDEST'(ov);

endmodule

// File: tb/tb_stream_dispatcher.sv
// Self-checking bench for stream_dispatcher: vector table, corner
// sequences and randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_stream_dispatcher;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic        in_dest_en = 1'b0;
   logic [1:0]  in_dest = '0;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready = '0;
   logic [15:0] out_data;
   logic [1:0]  sel;
   logic [15:0] dispatch_count;

   int checks = 0;
   int failures = 0;

   stream_dispatcher #(.WIDTH(16), .NDEST(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .in_dest_en     (in_dest_en),
      .in_dest        (in_dest),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .sel            (sel),
      .dispatch_count (dispatch_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: sim time exceeded, want finish");
      $fatal(1, "timeout");
   end

   // Behavioural model: one optional held word with its destination.
   bit          m_valid = 0;
   logic [15:0] m_data = '0;
   int          m_dest = 0;
   int          m_ptr = 0;
   int          m_cnt = 0;
   bit          m_rr = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_chk();
      logic [3:0] eov;
      logic       erdy;
      eov  = m_valid ? (4'b0001 << m_dest) : 4'b0000;
      erdy = rst_n && (!m_valid || out_ready[m_dest]);
      chk("m_in_ready", 32'(in_ready), 32'(erdy));
      chk("m_out_valid", 32'(out_valid), 32'(eov));
      chk("m_out_data", 32'(out_data), 32'(m_data));
      chk("m_sel", 32'(sel), 32'(m_dest));
      chk("m_count", 32'(dispatch_count), 32'(m_cnt));
   endtask

   task automatic model_upd();
      bit disp;
      bit acc;
      if (!rst_n) begin
         m_valid = 0; m_data = '0; m_dest = 0;
         m_ptr = 0; m_cnt = 0; m_rr = 0;
      end else begin
         disp = m_valid && out_ready[m_dest];
         acc  = in_valid && (!m_valid || disp);
         if (disp) begin
            m_cnt = (m_cnt + 1) % 65536;
            if (m_rr) m_ptr = (m_ptr + 1) % 4;
            m_valid = 0;
         end
         if (acc) begin
            m_valid = 1;
            m_data  = in_data;
            m_rr    = !in_dest_en;
            m_dest  = in_dest_en ? int'(in_dest) : m_ptr;
         end
      end
   endtask

   task automatic drive(input logic r, input logic v,
                        input logic [15:0] d, input logic en,
                        input logic [1:0] dst, input logic [3:0] ordy);
      rst_n = r; in_valid = v; in_data = d;
      in_dest_en = en; in_dest = dst; out_ready = ordy;
   endtask

   task automatic step(input bit do_chk);
      #1;
      if (do_chk) model_chk();
      @(posedge clk);
      model_upd();
      @(negedge clk);
   endtask

   typedef struct {
      logic        v;
      logic [15:0] d;
      logic        en;
      logic [1:0]  dst;
      logic [3:0]  ordy;
      logic        e_rdy;
      logic [3:0]  e_ov;
      logic [1:0]  e_sel;
      logic [15:0] e_data;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t tbl[12];

   initial begin
      // round-robin burst 1..5, then RR / directed(3) / RR mix
      tbl[0]  = '{1, 16'h0001, 0, 0, 4'hF, 1, 4'b0000, 0, 16'h0000, 0};
      tbl[1]  = '{1, 16'h0002, 0, 0, 4'hF, 1, 4'b0001, 0, 16'h0001, 0};
      tbl[2]  = '{1, 16'h0003, 0, 0, 4'hF, 1, 4'b0010, 1, 16'h0002, 1};
      tbl[3]  = '{1, 16'h0004, 0, 0, 4'hF, 1, 4'b0100, 2, 16'h0003, 2};
      tbl[4]  = '{1, 16'h0005, 0, 0, 4'hF, 1, 4'b1000, 3, 16'h0004, 3};
      tbl[5]  = '{0, 16'h0000, 0, 0, 4'hF, 1, 4'b0001, 0, 16'h0005, 4};
      tbl[6]  = '{0, 16'h0000, 0, 0, 4'hF, 1, 4'b0000, 0, 16'h0005, 5};
      tbl[7]  = '{1, 16'h0011, 0, 0, 4'hF, 1, 4'b0000, 0, 16'h0005, 5};
      tbl[8]  = '{1, 16'h0022, 1, 3, 4'hF, 1, 4'b0010, 1, 16'h0011, 5};
      tbl[9]  = '{1, 16'h0033, 0, 0, 4'hF, 1, 4'b1000, 3, 16'h0022, 6};
      tbl[10] = '{0, 16'h0000, 0, 0, 4'hF, 1, 4'b0100, 2, 16'h0033, 7};
      tbl[11] = '{0, 16'h0000, 0, 0, 4'hF, 1, 4'b0000, 2, 16'h0033, 8};

      // reset two cycles with in_valid high
      @(negedge clk);
      drive(0, 1, 16'hFFFF, 0, 0, 4'hF);
      step(0);
      step(0);
      #1;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_count", 32'(dispatch_count), 0);
      chk("rst_sel", 32'(sel), 0);
      chk("rst_out_data", 32'(out_data), 0);
      @(negedge clk);
      model_upd();

      foreach (tbl[i]) begin
         drive(1, tbl[i].v, tbl[i].d, tbl[i].en, tbl[i].dst, tbl[i].ordy);
         #1;
         chk($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
         chk($sformatf("vec%0d_ov", i), 32'(out_valid), 32'(tbl[i].e_ov));
         chk($sformatf("vec%0d_sel", i), 32'(sel), 32'(tbl[i].e_sel));
         chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(tbl[i].e_data));
         chk($sformatf("vec%0d_cnt", i), 32'(dispatch_count), 32'(tbl[i].e_cnt));
         step(1);
      end

      // backpressure on dest 2; other ready bits must not matter
      drive(1, 1, 16'hABCD, 1, 2, 4'b1011);
      step(1);
      for (int k = 0; k < 3; k++) begin
         drive(1, 1, 16'h1234, 0, 0, 4'b1011);
         #1;
         chk("bp_ov", 32'(out_valid), 32'(4'b0100));
         chk("bp_data", 32'(out_data), 32'h0000ABCD);
         chk("bp_ready", 32'(in_ready), 0);
         step(1);
      end
      drive(1, 0, 16'h0000, 0, 0, 4'b1111);
      #1;
      chk("bp_release_ready", 32'(in_ready), 1);
      step(1);
      #1;
      chk("bp_count", 32'(dispatch_count), 9);
      chk("bp_ov_after", 32'(out_valid), 0);

      // mid-operation reset discards a held word
      drive(1, 1, 16'h5555, 1, 1, 4'b1101);
      step(1);
      #1;
      chk("mr_held_ov", 32'(out_valid), 32'(4'b0010));
      drive(0, 1, 16'h9999, 0, 0, 4'b1111);
      #1;
      chk("mr_ready_in_rst", 32'(in_ready), 0);
      step(1);
      #1;
      chk("mr_ov", 32'(out_valid), 0);
      chk("mr_count", 32'(dispatch_count), 0);
      drive(1, 1, 16'h7777, 0, 0, 4'b0000);
      step(1);
      #1;
      chk("mr_rr_sel", 32'(sel), 0);
      chk("mr_rr_ov", 32'(out_valid), 32'(4'b0001));
      drive(1, 0, 16'h0000, 0, 0, 4'b1111);
      step(1);
      #1;
      chk("mr_count_after", 32'(dispatch_count), 1);

      // counter wrap: stream to 65535 dispatches, then one more
      for (int k = 0; k < 65535; k++) begin
         drive(1, 1, 16'(k), 0, 0, 4'b1111);
         step(1);
      end
      #1;
      chk("wrap_ffff", 32'(dispatch_count), 32'h0000FFFF);
      drive(1, 0, 16'h0000, 0, 0, 4'b1111);
      step(1);
      #1;
      chk("wrap_zero", 32'(dispatch_count), 0);

      // randomized traffic with occasional reset
      for (int k = 0; k < 3000; k++) begin
         drive(($urandom_range(0, 49) != 0), 1'($urandom),
               16'($urandom), 1'($urandom), 2'($urandom),
               4'($urandom));
         step(1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/stream_dispatcher.md
STREAM_DISPATCHER -- requirements
Module: stream_dispatcher

Interface
REQ-001 Parameter WIDTH, 16, data word width (Hack word).
REQ-002 Parameter NDEST, 4, number of destinations; fixed at 4, sel is 2 bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  source presents a word.
REQ-006 in_ready  output  1  dispatcher accepts the word this cycle.
REQ-007 in_data  input  WIDTH  source word.
REQ-008 in_dest_en  input  1  1 = directed routing via in_dest; 0 = round-robin.
REQ-009 in_dest  input  2  directed destination index.
REQ-010 out_valid  output  NDEST  one-hot valid toward the selected destination; all-zero when empty.
REQ-011 out_ready  input  NDEST  per-destination ready.
REQ-012 out_data  output  WIDTH  held word, broadcast to all destinations.
REQ-013 sel  output  2  index of current destination (demux select).
REQ-014 dispatch_count  output  16  number of completed dispatches, wraps at 16'hFFFF -> 0.

Function
REQ-015 The block SHALL hold at most one word; states EMPTY and HOLD.
REQ-016 Accept = in_valid & in_ready; dispatch = HOLD & out_ready[sel].
REQ-017 in_ready SHALL be 1 in EMPTY, and 1 in HOLD only when dispatch occurs that cycle (combinational from out_ready[sel]).
REQ-018 On accept, the word SHALL be registered into out_data and sel fixed for that word: in_dest if in_dest_en=1, else rr_ptr.
REQ-019 Latency: a word accepted at edge N SHALL drive out_valid from after edge N; earliest dispatch at edge N+1.
REQ-020 Throughput: with the target ready, one word per cycle (dispatch and accept on the same edge -> stay HOLD with new word).
REQ-021 out_valid[k] SHALL equal (state==HOLD) & (k==sel); out_valid, out_data and sel SHALL remain stable while HOLD and not dispatched.
REQ-022 A destination other than sel asserting out_ready SHALL have no effect; no re-routing of a held word.
REQ-023 Transitions: EMPTY --accept--> HOLD; HOLD --dispatch & !accept--> EMPTY; HOLD --dispatch & accept--> HOLD; otherwise stay.
REQ-024 rr_ptr (2 bits) SHALL advance by 1 mod 4 only on dispatch of a round-robin word (3 -> 0 wrap); directed words SHALL leave rr_ptr unchanged.
REQ-025 dispatch_count SHALL increment by 1 on each dispatch, both routing modes.
REQ-026 In EMPTY, sel SHALL show its last value; out_data holds the last word (don't-care to consumers).

Reset
REQ-027 rst_n=0 at a rising edge SHALL force state=EMPTY, out_valid=0, sel=0, rr_ptr=0, out_data=0, dispatch_count=0.
REQ-028 While rst_n=0, in_ready SHALL be 0; a word held at reset is discarded, not dispatched.
REQ-029 First accept possible at the first edge with rst_n=1.

Structure
REQ-030 State encodings (EMPTY, HOLD) and NDEST/select-width constants SHALL live in the shared package/include with the other word-width constants.
REQ-031 The one-hot out_valid decode SHALL be one sub-module, dmux4way (1-bit in, 2-bit sel, 4 outputs), instantiated with in = HOLD flag.
REQ-032 Target size 120-400 lines of RTL; no memories, no other clocks.

Verification
REQ-033 Reset: rst_n=0 two cycles with in_valid=1 -> out_valid=0000, in_ready=0, dispatch_count=0, sel=0.
REQ-034 Round-robin: all out_ready=1111, send 16'h0001..16'h0005 back-to-back, in_dest_en=0 -> dispatched to dests 0,1,2,3,0, one per cycle, dispatch_count=5.
REQ-035 Backpressure: word 16'hABCD to dest 2 with out_ready=1011 for 3 cycles -> out_valid=0100 stable, out_data=ABCD, in_ready=0; raise bit 2 -> dispatch next edge, count+1.
REQ-036 Directed vs RR mix: RR word (rr_ptr=1), then directed in_dest=3, then RR -> dests 1,3,2; rr_ptr not advanced by directed word.
REQ-037 Counter wrap: preload via 65535 dispatches, one more -> dispatch_count=0.
REQ-038 Mid-operation reset: word held at dest 1 not ready, assert rst_n=0 one cycle -> out_valid=0000, word never dispatched, rr_ptr=0.
